dbus_arbiter: RTL and testbench

- Two-master arbiter for the single data-memory port, i.e. the word-addressed dmem/MMIO bus driven after the data aligner.
- Master 0 is the core MEM stage; master 1 is the loader/debug DMA engine that fills dmem over the host link.
- Core has default priority. The loader gets a guaranteed slot after a bounded wait, or holds the bus for locked bursts. The core is stalled whenever it loses a cycle.
- Sits between daligner and the dmem/LED decode, in the CLK75 domain.

---
 rtl/dbus_pkg.sv | 19 +
 rtl/dbus_wait_ctr.sv | 37 +++
 rtl/dbus_arbiter.sv | 113 +++++++++++
 tb/tb_dbus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared encodings and bus widths for the data-bus arbiter.
package dbus_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STB_W  = 4;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_CORE   = 2'd1,
        RD_LOADER = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/dbus_wait_ctr.sv
// Saturating starvation counter: counts refused loader cycles up to MAX_WAIT.
module dbus_wait_ctr #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the data-memory port: core has default priority,
// loader is forced in after a bounded wait or keeps the bus for locked bursts.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              C_REQ,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    input  logic [STB_W-1:0]  C_WSTB,
    output logic              C_STALL,
    output logic [DATA_W-1:0] C_RDATA,
    output logic              C_RVALID,
    input  logic              L_REQ,
    input  logic [ADDR_W-1:0] L_ADDR,
    input  logic [DATA_W-1:0] L_WDATA,
    input  logic [STB_W-1:0]  L_WSTB,
    input  logic              L_LOCK,
    output logic              L_GNT,
    output logic [DATA_W-1:0] L_RDATA,
    output logic              L_RVALID,
    output logic              M_CE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_DATAO,
    output logic [STB_W-1:0]  M_WSTB,
    input  logic [DATA_W-1:0] M_DATAI
);

    owner_e    owner_q, owner_d;
    rd_owner_e rd_owner_q, rd_owner_d;
    logic      l_gnt, c_gnt, at_max;

    dbus_wait_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_ctr (
        .clk_i    (CLK),
        .srst_i   (RST),
        .clr_i    (l_gnt || !L_REQ),
        .inc_i    (L_REQ && !l_gnt),
        .at_max_o (at_max)
    );

    // Grants are forced low during reset so every output sits at its idle value.
    always_comb begin
        l_gnt      = 1'b0;
        c_gnt      = 1'b0;
        owner_d    = owner_q;
        rd_owner_d = RD_NONE;
        if (!RST) begin
            if (owner_q == OWN_LOADER) begin
                l_gnt = L_REQ;
            end else begin
                l_gnt = L_REQ && (!C_REQ || at_max);
                c_gnt = C_REQ && !l_gnt;
            end

            if (l_gnt) begin
                owner_d = L_LOCK ? OWN_LOADER : OWN_CORE;
            end else if (!L_REQ) begin
                owner_d = OWN_CORE;
            end

            if (l_gnt && (L_WSTB == '0)) begin
                rd_owner_d = RD_LOADER;
            end else if (c_gnt && (C_WSTB == '0)) begin
                rd_owner_d = RD_CORE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q    <= OWN_CORE;
            rd_owner_q <= RD_NONE;
        end else begin
            owner_q    <= owner_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        M_CE    = 1'b0;
        M_ADDR  = '0;
        M_DATAO = '0;
        M_WSTB  = '0;
        if (l_gnt) begin
            M_CE    = 1'b1;
            M_ADDR  = L_ADDR;
            M_DATAO = L_WDATA;
            M_WSTB  = L_WSTB;
        end else if (c_gnt) begin
            M_CE    = 1'b1;
            M_ADDR  = C_ADDR;
            M_DATAO = C_WDATA;
            M_WSTB  = C_WSTB;
        end
    end

    assign C_STALL  = C_REQ && !c_gnt && !RST;
    assign L_GNT    = l_gnt;

    // A read issued just before reset is dropped, not replayed.
    assign C_RVALID = !RST && (rd_owner_q == RD_CORE);
    assign L_RVALID = !RST && (rd_owner_q == RD_LOADER);
    assign C_RDATA  = C_RVALID ? M_DATAI : '0;
    assign L_RDATA  = L_RVALID ? M_DATAI : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomised and directed bench for dbus_arbiter with an in-bench reference model.
module tb_dbus_arbiter;

    localparam int MAX_WAIT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        C_REQ;
    logic [29:0] C_ADDR;
    logic [31:0] C_WDATA;
    logic [3:0]  C_WSTB;
    logic        C_STALL;
    logic [31:0] C_RDATA;
    logic        C_RVALID;
    logic        L_REQ;
    logic [29:0] L_ADDR;
    logic [31:0] L_WDATA;
    logic [3:0]  L_WSTB;
    logic        L_LOCK;
    logic        L_GNT;
    logic [31:0] L_RDATA;
    logic        L_RVALID;
    logic        M_CE;
    logic [29:0] M_ADDR;
    logic [31:0] M_DATAO;
    logic [3:0]  M_WSTB;
    logic [31:0] M_DATAI;

    int errors = 0;
    int checks = 0;

    dbus_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .C_REQ(C_REQ), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA), .C_WSTB(C_WSTB),
        .C_STALL(C_STALL), .C_RDATA(C_RDATA), .C_RVALID(C_RVALID),
        .L_REQ(L_REQ), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA), .L_WSTB(L_WSTB),
        .L_LOCK(L_LOCK), .L_GNT(L_GNT), .L_RDATA(L_RDATA), .L_RVALID(L_RVALID),
        .M_CE(M_CE), .M_ADDR(M_ADDR), .M_DATAO(M_DATAO), .M_WSTB(M_WSTB),
        .M_DATAI(M_DATAI)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: loader "holds" the bus after any grant made with lock;
    // "waited" counts refused loader cycles; "pend" tags the read owed next cycle.
    bit model_locked = 1'b0;
    int model_waited = 0;
    int model_pend   = 0;   // 0 none, 1 core, 2 loader

    always @(negedge CLK) begin
        bit lg, cg, lrd, crd;
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        lg = 1'b0;
        cg = 1'b0;
        if (!RST) begin
            if (model_locked) lg = L_REQ;
            else              lg = L_REQ && (!C_REQ || model_waited == MAX_WAIT);
            cg = C_REQ && !lg && !model_locked;
        end
        ea = lg ? L_ADDR  : (cg ? C_ADDR  : 30'd0);
        ed = lg ? L_WDATA : (cg ? C_WDATA : 32'd0);
        es = lg ? L_WSTB  : (cg ? C_WSTB  : 4'd0);
        crd = !RST && model_pend == 1;
        lrd = !RST && model_pend == 2;

        chk("L_GNT",    {31'd0, L_GNT},    {31'd0, lg});
        chk("C_STALL",  {31'd0, C_STALL},  {31'd0, (!RST && C_REQ && !cg)});
        chk("M_CE",     {31'd0, M_CE},     {31'd0, (lg || cg)});
        chk("M_ADDR",   {2'd0, M_ADDR},    {2'd0, ea});
        chk("M_DATAO",  M_DATAO,           ed);
        chk("M_WSTB",   {28'd0, M_WSTB},   {28'd0, es});
        chk("C_RVALID", {31'd0, C_RVALID}, {31'd0, crd});
        chk("L_RVALID", {31'd0, L_RVALID}, {31'd0, lrd});
        chk("C_RDATA",  C_RDATA,           crd ? M_DATAI : 32'd0);
        chk("L_RDATA",  L_RDATA,           lrd ? M_DATAI : 32'd0);

        if (RST) begin
            model_locked = 1'b0;
            model_waited = 0;
            model_pend   = 0;
        end else begin
            if (lg && L_WSTB == 4'd0)      model_pend = 2;
            else if (cg && C_WSTB == 4'd0) model_pend = 1;
            else                           model_pend = 0;
            if (L_REQ && !lg) model_waited = (model_waited < MAX_WAIT) ? model_waited + 1 : MAX_WAIT;
            else              model_waited = 0;
            model_locked = lg && L_LOCK;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0;
        C_REQ = 1'b0; C_ADDR = '0; C_WDATA = '0; C_WSTB = '0;
        L_REQ = 1'b0; L_ADDR = '0; L_WDATA = '0; L_WSTB = '0; L_LOCK = 1'b0;
        M_DATAI = $urandom;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        C_REQ = 1'b1;
        L_REQ = 1'b1;
        L_LOCK = 1'b1;

        // Reset held with both masters requesting: nothing granted.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("rst_L_GNT", {31'd0, L_GNT}, 32'd0);
            chk("rst_M_CE", {31'd0, M_CE}, 32'd0);
            chk("rst_C_STALL", {31'd0, C_STALL}, 32'd0);
            next_cycle();
        end
        idle();
        @(negedge CLK);
        chk("post_rst_rvalid", {30'd0, C_RVALID, L_RVALID}, 32'd0);

        // Core-only read.
        next_cycle();
        idle();
        C_REQ = 1'b1; C_ADDR = 30'h0004_0000;
        @(negedge CLK);
        chk("cread_M_ADDR", {2'd0, M_ADDR}, 32'h0004_0000);
        chk("cread_C_STALL", {31'd0, C_STALL}, 32'd0);
        next_cycle();
        idle();
        M_DATAI = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("cread_C_RVALID", {31'd0, C_RVALID}, 32'd1);
        chk("cread_C_RDATA", C_RDATA, 32'hDEAD_BEEF);
        chk("cread_L_RVALID", {31'd0, L_RVALID}, 32'd0);

        // Continuous contention: loader forced in on the ninth cycle.
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            idle();
            C_REQ = 1'b1; C_ADDR = 30'h100;
            L_REQ = 1'b1; L_ADDR = 30'h200;
            @(negedge CLK);
            chk($sformatf("cont_L_GNT_%0d", k), {31'd0, L_GNT}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("cont_M_ADDR_%0d", k), {2'd0, M_ADDR}, (k == 8) ? 32'h200 : 32'h100);
        end

        next_cycle();
        idle();
        @(negedge CLK);

        // Locked burst of four writes once the loader wins.
        for (int k = 0; k < 13; k++) begin
            next_cycle();
            idle();
            C_REQ = 1'b1; C_ADDR = 30'h300; C_WSTB = 4'h0;
            L_REQ = (k < 12); L_ADDR = 30'h400 + 30'(k); L_WSTB = 4'hF;
            L_WDATA = (k < 8) ? 32'd1 : 32'(k - 7);
            L_LOCK = (k < 11);
            @(negedge CLK);
            if (k >= 8 && k < 12) begin
                chk($sformatf("burst_L_GNT_%0d", k), {31'd0, L_GNT}, 32'd1);
                chk($sformatf("burst_C_STALL_%0d", k), {31'd0, C_STALL}, 32'd1);
                chk($sformatf("burst_M_DATAO_%0d", k), M_DATAO, 32'(k - 7));
                chk($sformatf("burst_L_RVALID_%0d", k), {31'd0, L_RVALID}, 32'd0);
            end
            if (k == 12) begin
                chk("burst_end_C_STALL", {31'd0, C_STALL}, 32'd0);
                chk("burst_end_M_ADDR", {2'd0, M_ADDR}, 32'h300);
            end
        end

        // Core read then loader read back to back.
        next_cycle();
        idle();
        C_REQ = 1'b1; C_ADDR = 30'h10;
        next_cycle();
        idle();
        L_REQ = 1'b1; L_ADDR = 30'h20;
        M_DATAI = 32'h1111_1111;
        @(negedge CLK);
        chk("alt_L_GNT", {31'd0, L_GNT}, 32'd1);
        chk("alt_C_RDATA", C_RDATA, 32'h1111_1111);
        chk("alt_L_RVALID0", {31'd0, L_RVALID}, 32'd0);
        next_cycle();
        idle();
        M_DATAI = 32'h2222_2222;
        @(negedge CLK);
        chk("alt_L_RDATA", L_RDATA, 32'h2222_2222);
        chk("alt_C_RVALID1", {31'd0, C_RVALID}, 32'd0);
        chk("alt_C_RDATA1", C_RDATA, 32'd0);

        // Core partial-strobe write.
        next_cycle();
        idle();
        C_REQ = 1'b1; C_ADDR = 30'h55; C_WSTB = 4'b0010; C_WDATA = 32'h0000_AB00;
        @(negedge CLK);
        chk("bw_M_WSTB", {28'd0, M_WSTB}, 32'h2);
        chk("bw_M_DATAO", M_DATAO, 32'h0000_AB00);
        chk("bw_M_CE", {31'd0, M_CE}, 32'd1);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("bw_no_rvalid", {30'd0, C_RVALID, L_RVALID}, 32'd0);

        // Reset the cycle after a granted loader read.
        next_cycle();
        idle();
        L_REQ = 1'b1; L_ADDR = 30'h77;
        @(negedge CLK);
        chk("rmid_L_GNT", {31'd0, L_GNT}, 32'd1);
        next_cycle();
        idle();
        RST = 1'b1;
        @(negedge CLK);
        chk("rmid_L_RVALID", {31'd0, L_RVALID}, 32'd0);
        chk("rmid_L_RDATA", L_RDATA, 32'd0);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("rmid_after_L_RVALID", {31'd0, L_RVALID}, 32'd0);
        chk("rmid_after_M_CE", {31'd0, M_CE}, 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            RST     = ($urandom_range(0, 63) == 0);
            C_REQ   = ($urandom_range(0, 3) != 0);
            C_ADDR  = 30'($urandom);
            C_WDATA = $urandom;
            C_WSTB  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            L_REQ   = ($urandom_range(0, 2) != 0);
            L_ADDR  = 30'($urandom);
            L_WDATA = $urandom;
            L_WSTB  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            L_LOCK  = ($urandom_range(0, 2) == 0);
            M_DATAI = $urandom;
        end

        next_cycle();
        idle();
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
